// File: rtl/tt_gate_settled_pkg.sv
// Shared types and helpers for the programmable truth-table gate family.
//   tt_state_e : settle FSM encoding (SETTLING, STABLE)
//   tt_eval    : looks up one row of an MSB-first truth table. It is also used
//                by the case-gate generator, so the convention lives in one place.
package cello_gate_pkg;

    typedef enum logic {
        SETTLING = 1'b0,
        STABLE   = 1'b1
    } tt_state_e;

    // Widest table supported (N_IN up to 6).
    localparam int unsigned TT_MAX_W = 64;

    // Row r of a tt_w-bit table sits at bit (tt_w-1-r): row 0 is the MSB.
    function automatic logic tt_eval(input logic [TT_MAX_W-1:0] tt,
                                     input int unsigned         tt_w,
                                     input logic [5:0]          row);
        logic [5:0] pos;
        pos = 6'(tt_w - 32'(row) - 32'd1);
        return tt[pos];
    endfunction

endpackage

// File: rtl/tt_gate_settled_if.sv
// Bus bundle for tt_gate_settled.
//   in_bits   : logic inputs (in_bits[N_IN-1] is the row MSB)
//   cfg_*     : truth-table load handshake
//   out/out_valid : settled gate output
//   tt_q      : current truth table readback
//   dbg_state : settle FSM state, for observation only
//
// Handshake: a table transfer happens on a rising clk edge where
// cfg_valid & cfg_ready are both 1. The master keeps cfg_valid and cfg_tt
// steady until that edge; cfg_valid while cfg_ready=0 has no effect.
interface tt_gate_settled_if #(
    parameter int N_IN = 3
);
    import cello_gate_pkg::*;

    localparam int TT_W = 2 ** N_IN;

    logic [N_IN-1:0] in_bits;
    logic            cfg_valid;
    logic [TT_W-1:0] cfg_tt;
    logic            cfg_ready;
    logic            out;
    logic            out_valid;
    logic [TT_W-1:0] tt_q;
    tt_state_e       dbg_state;

    modport master (
        output in_bits, cfg_valid, cfg_tt,
        input  cfg_ready, out, out_valid, tt_q, dbg_state
    );

    modport slave (
        input  in_bits, cfg_valid, cfg_tt,
        output cfg_ready, out, out_valid, tt_q, dbg_state
    );

endinterface

// File: rtl/tt_gate_settled_timer.sv
// Settle timer for tt_gate_settled.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   en_i           : 1 while the gate is SETTLING (the count advances)
//   in_bits_i      : live inputs
//   idx_i          : inputs as sampled on the previous edge
//   cfg_xfer_i     : table transfer happening at this edge
//   restart_o      : input changed or table reloaded; settling starts over
//   done_o         : inputs have been stable for SETTLE edges (one-edge pulse)
module tt_settle_timer #(
    parameter int SETTLE = 4,
    parameter int N_IN   = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [N_IN-1:0] in_bits_i,
    input  logic [N_IN-1:0] idx_i,
    input  logic            cfg_xfer_i,
    output logic            restart_o,
    output logic            done_o
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign restart_o = (in_bits_i != idx_i) || cfg_xfer_i;
    assign done_o    = en_i && !restart_o && (cnt_q == LAST);

    // The count parks at LAST once done so it never exceeds SETTLE-1;
    // it only moves again after a restart.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_o) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_gate_settled.sv
// Programmable N-input truth-table gate with input settling.
// The output only updates after the input pattern has held for SETTLE edges,
// modelling regulator response delay and filtering glitches.
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : tt_gate_settled_if.slave (inputs, table load handshake, output,
//          table readback, FSM state)
module tt_gate_settled
    import cello_gate_pkg::*;
#(
    parameter int                    N_IN    = 3,
    parameter logic [(2**N_IN)-1:0]  TT_INIT = 'hF4,
    parameter int                    SETTLE  = 4
) (
    input  logic                clk,
    input  logic                rst,
    tt_gate_settled_if.slave    bus
);

    localparam int TT_W = 2 ** N_IN;

    logic [TT_W-1:0] tt_q;
    logic [N_IN-1:0] idx_q;
    tt_state_e       state_q;
    logic            out_q;
    logic            out_valid_q;

    logic cfg_ready;
    logic cfg_xfer;
    logic restart;
    logic done;

    // A load is only accepted once the output has settled.
    assign cfg_ready = (state_q == STABLE);
    assign cfg_xfer  = bus.cfg_valid && cfg_ready;

    tt_settle_timer #(
        .SETTLE (SETTLE),
        .N_IN   (N_IN)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (state_q == SETTLING),
        .in_bits_i  (bus.in_bits),
        .idx_i      (idx_q),
        .cfg_xfer_i (cfg_xfer),
        .restart_o  (restart),
        .done_o     (done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q        <= TT_INIT;
            idx_q       <= '0;
            state_q     <= SETTLING;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            idx_q <= bus.in_bits;
            if (cfg_xfer) begin
                tt_q <= bus.cfg_tt;
            end
            // out is left untouched on restart so it cannot glitch.
            if (restart) begin
                state_q     <= SETTLING;
                out_valid_q <= 1'b0;
            end else if ((state_q == SETTLING) && done) begin
                out_q       <= tt_eval(TT_MAX_W'(tt_q), 32'(TT_W), 6'(idx_q));
                out_valid_q <= 1'b1;
                state_q     <= STABLE;
            end
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.tt_q      = tt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tt_gate_settled.sv
// Directed bench for tt_gate_settled (N_IN=3, TT_INIT=0xF4, SETTLE=4).
module tb_tt_gate_settled;
    import cello_gate_pkg::*;

    logic clk;
    logic rst;
    int   num_checks;
    int   num_errors;

    tt_gate_settled_if #(.N_IN(3)) bus ();

    tt_gate_settled #(
        .N_IN    (3),
        .TT_INIT (8'hF4),
        .SETTLE  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance n edges; sample/drive 1ns after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [2:0] v);
        bus.in_bits = v;
    endtask

    task automatic offer_cfg(input logic v, input logic [7:0] tt);
        bus.cfg_valid = v;
        bus.cfg_tt    = tt;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expect n edges with out_valid=0 and out frozen at held_out.
    task automatic expect_settling(input string tag, input int n, input logic held_out);
        for (int i = 0; i < n; i++) begin
            step(1);
            check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
            check({tag, "_hold"},  64'(bus.out), 64'(held_out));
        end
    endtask

    // Hand-derived rows of 0xF4, MSB-first: 1,1,1,1,0,1,0,0
    logic exp_f4 [8];

    initial begin
        exp_f4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        num_checks = 0;
        num_errors = 0;
        rst = 1'b1;
        set_in(3'b000);
        offer_cfg(1'b0, 8'h00);

        // ---- 1: reset and first settle ----
        step(2);
        check("rst_out",       64'(bus.out), 64'd0);
        check("rst_valid",     64'(bus.out_valid), 64'd0);
        check("rst_tt",        64'(bus.tt_q), 64'hF4);
        check("rst_ready",     64'(bus.cfg_ready), 64'd0);
        check("rst_state",     64'(bus.dbg_state), 64'(SETTLING));
        rst = 1'b0;
        expect_settling("t1", 3, 1'b0);
        step(1);
        check("t1_out",        64'(bus.out), 64'd1);
        check("t1_valid",      64'(bus.out_valid), 64'd1);
        check("t1_ready",      64'(bus.cfg_ready), 64'd1);
        check("t1_state",      64'(bus.dbg_state), 64'(STABLE));

        // ---- 2: sweep rows 1..7, 6 cycles each, update exactly 4 edges on ----
        for (int r = 1; r < 8; r++) begin
            set_in(3'(r));
            expect_settling($sformatf("t2_r%0d", r), 4, exp_f4[r-1]);
            step(1);
            check($sformatf("t2_r%0d_out", r),   64'(bus.out), 64'(exp_f4[r]));
            check($sformatf("t2_r%0d_valid", r), 64'(bus.out_valid), 64'd1);
            step(1);
        end

        // ---- 3: toggle 100/101 every 2 cycles: out frozen at 0 ----
        for (int i = 0; i < 10; i++) begin
            set_in((i % 2 == 1) ? 3'b101 : 3'b100);
            expect_settling($sformatf("t3_%0d", i), 2, 1'b0);
        end
        set_in(3'b000);
        expect_settling("t3_back", 4, 1'b0);
        step(1);
        check("t3_out",        64'(bus.out), 64'd1);
        check("t3_valid",      64'(bus.out_valid), 64'd1);

        // ---- 4: load 0x7F while STABLE, row 0 goes 1 -> 0 ----
        offer_cfg(1'b1, 8'h7F);
        check("t4_ready",      64'(bus.cfg_ready), 64'd1);
        step(1);
        offer_cfg(1'b0, 8'h00);
        check("t4_tt",         64'(bus.tt_q), 64'h7F);
        check("t4_ready_drop", 64'(bus.cfg_ready), 64'd0);
        check("t4_valid_drop", 64'(bus.out_valid), 64'd0);
        expect_settling("t4", 3, 1'b1);
        step(1);
        check("t4_out",        64'(bus.out), 64'd0);
        check("t4_valid",      64'(bus.out_valid), 64'd1);

        // ---- 5: cfg offered while SETTLING waits for STABLE ----
        set_in(3'b001);
        step(1);
        offer_cfg(1'b1, 8'h80);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("t5_tt_held",  64'(bus.tt_q), 64'h7F);
            check("t5_not_rdy",  64'(bus.cfg_ready), 64'd0);
        end
        step(1);
        // row 1 of 0x7F is 1
        check("t5_out_old",    64'(bus.out), 64'd1);
        check("t5_ready",      64'(bus.cfg_ready), 64'd1);
        check("t5_tt_still",   64'(bus.tt_q), 64'h7F);
        step(1);
        offer_cfg(1'b0, 8'h00);
        check("t5_tt_loaded",  64'(bus.tt_q), 64'h80);
        check("t5_valid_drop", 64'(bus.out_valid), 64'd0);
        expect_settling("t5", 3, 1'b1);
        step(1);
        // row 1 of 0x80 is 0
        check("t5_out",        64'(bus.out), 64'd0);
        check("t5_valid",      64'(bus.out_valid), 64'd1);

        // ---- 7: input change and load on the same edge ----
        set_in(3'b100);
        offer_cfg(1'b1, 8'h08);
        step(1);
        offer_cfg(1'b0, 8'h00);
        check("t7_tt",         64'(bus.tt_q), 64'h08);
        check("t7_valid_drop", 64'(bus.out_valid), 64'd0);
        expect_settling("t7", 3, 1'b0);
        step(1);
        // row 4 of 0x08 is 1 (0xF4 would give 0)
        check("t7_out",        64'(bus.out), 64'd1);
        check("t7_valid",      64'(bus.out_valid), 64'd1);

        // ---- identical reload still restarts ----
        offer_cfg(1'b1, 8'h08);
        step(1);
        check("same_valid",    64'(bus.out_valid), 64'd0);
        check("same_out",      64'(bus.out), 64'd1);

        // ---- 6: reset mid-settle with a pending cfg ----
        offer_cfg(1'b1, 8'h55);
        step(1);
        check("t6_pending_tt", 64'(bus.tt_q), 64'h08);
        rst = 1'b1;
        step(1);
        check("t6_tt",         64'(bus.tt_q), 64'hF4);
        check("t6_out",        64'(bus.out), 64'd0);
        check("t6_valid",      64'(bus.out_valid), 64'd0);
        check("t6_state",      64'(bus.dbg_state), 64'(SETTLING));
        rst = 1'b0;
        offer_cfg(1'b0, 8'h00);
        set_in(3'b000);
        expect_settling("t6", 3, 1'b0);
        step(1);
        check("t6_out_after",  64'(bus.out), 64'd1);
        check("t6_valid_after",64'(bus.out_valid), 64'd1);
        check("t6_tt_after",   64'(bus.tt_q), 64'hF4);

        // ---- final report ----
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
